fpu_cmp_pipe: RTL and testbench

FPU_CMP_PIPE -- requirements
Module: fpu_cmp_pipe

---
 rtl/fpu_cmp_pkg.sv | 32 +++
 rtl/fpu_cmp_classify.sv | 40 ++++
 rtl/fpu_cmp_pipe.sv | 151 +++++++++++++++
 tb/tb_fpu_cmp_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cmp_pkg.sv
// Shared types and constants for the floating-point compare pipeline.
package fpu_cmp_pkg;

   // Operand classification.
   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_DENORM,
      CLS_NORMAL,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   // x87-style condition codes {C3,C2,C0}.
   localparam logic [2:0] CC_GT = 3'b000;
   localparam logic [2:0] CC_LT = 3'b001;
   localparam logic [2:0] CC_EQ = 3'b100;
   localparam logic [2:0] CC_UN = 3'b111;

   // Per-request state carried from stage 1 to stage 2.
   typedef struct packed {
      logic nan;      // either operand is NaN
      logic inv;      // invalid-operation condition
      logic den;      // either raw operand is denormal
      logic zero;     // both effective magnitudes are zero
      logic sa;       // sign of a
      logic sb;       // sign of b
      logic mag_lt;   // |a| < |b| on effective magnitude bits
      logic mag_eq;   // |a| == |b| on effective magnitude bits
   } s1_info_t;

endpackage

// File: rtl/fpu_cmp_classify.sv
// Classifies one IEEE-754 operand and produces its effective value
// (denormal flushed to signed zero when DAZ is set).
module fpu_cmp_classify
   import fpu_cmp_pkg::*;
#(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52,
   parameter int DAZ    = 1
) (
   input  logic [EXP_W+FRAC_W:0] op,
   output fp_class_e             cls,
   output logic [EXP_W+FRAC_W:0] eff
);

   localparam int W = 1 + EXP_W + FRAC_W;

   logic [EXP_W-1:0]  exp_f;
   logic [FRAC_W-1:0] frac_f;

   // Field decode, classification and optional denormal flush.
   always_comb begin
      exp_f  = op[W-2:FRAC_W];
      frac_f = op[FRAC_W-1:0];
      eff    = op;
      cls    = CLS_NORMAL;
      if (exp_f == '0) begin
         if (frac_f == '0) begin
            cls = CLS_ZERO;
         end else begin
            cls = CLS_DENORM;
            if (DAZ != 0) eff = {op[W-1], {(W-1){1'b0}}};
         end
      end else if (exp_f == '1) begin
         if (frac_f == '0)             cls = CLS_INF;
         else if (frac_f[FRAC_W-1])    cls = CLS_QNAN;
         else                          cls = CLS_SNAN;
      end
   end

endmodule

// File: rtl/fpu_cmp_pipe.sv
// Two-stage pipelined floating-point compare (FCOM/FUCOM) with
// valid/ready handshake, pass-through tag and sticky invalid flag.
module fpu_cmp_pipe
   import fpu_cmp_pkg::*;
#(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52,
   parameter int DAZ    = 1,
   parameter int TAG_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+FRAC_W:0]  in_a,
   input  logic [EXP_W+FRAC_W:0]  in_b,
   input  logic                   in_signaling,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_lt,
   output logic                   out_eq,
   output logic                   out_gt,
   output logic                   out_un,
   output logic [2:0]             out_cc,
   output logic                   out_invalid,
   output logic                   out_denormal,
   output logic [TAG_W-1:0]       out_tag,
   input  logic                   sticky_clr,
   output logic                   sticky_invalid
);

   localparam int W = 1 + EXP_W + FRAC_W;

   fp_class_e        cls_a, cls_b;
   logic [W-1:0]     eff_a, eff_b;
   s1_info_t         info_in;
   logic             stall;

   logic             s1_valid_q, s1_valid_d;
   s1_info_t         s1_info_q, s1_info_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             out_valid_q, out_valid_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, un_q, un_d;
   logic [2:0]       cc_q, cc_d;
   logic             inv_q, inv_d, den_q, den_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             sticky_q, sticky_d;

   fpu_cmp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .DAZ(DAZ)) u_cls_a (
      .op(in_a), .cls(cls_a), .eff(eff_a));
   fpu_cmp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .DAZ(DAZ)) u_cls_b (
      .op(in_b), .cls(cls_b), .eff(eff_b));

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~(s1_valid_q & stall);

   // Stage-1 datapath: NaN/invalid/denormal flags and magnitude compare.
   always_comb begin
      info_in.nan    = (cls_a inside {CLS_QNAN, CLS_SNAN}) | (cls_b inside {CLS_QNAN, CLS_SNAN});
      info_in.inv    = (cls_a == CLS_SNAN) | (cls_b == CLS_SNAN) | (in_signaling & info_in.nan);
      info_in.den    = (cls_a == CLS_DENORM) | (cls_b == CLS_DENORM);
      info_in.zero   = (eff_a[W-2:0] == '0) & (eff_b[W-2:0] == '0);
      info_in.sa     = eff_a[W-1];
      info_in.sb     = eff_b[W-1];
      info_in.mag_lt = eff_a[W-2:0] <  eff_b[W-2:0];
      info_in.mag_eq = eff_a[W-2:0] == eff_b[W-2:0];
   end

   // Stage-1 register load; holds while stage 2 is stalled and stage 1 is full.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_info_d  = s1_info_q;
      s1_tag_d   = s1_tag_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         s1_info_d  = info_in;
         s1_tag_d   = in_tag;
      end
   end

   // Stage-2 relation decode; outputs forced to zero for empty slots.
   always_comb begin
      out_valid_d = out_valid_q;
      lt_d = lt_q; eq_d = eq_q; gt_d = gt_q; un_d = un_q;
      cc_d = cc_q; inv_d = inv_q; den_d = den_q; tag_d = tag_q;
      if (!stall) begin
         out_valid_d = s1_valid_q;
         lt_d = 1'b0; eq_d = 1'b0; gt_d = 1'b0; un_d = 1'b0;
         cc_d = '0; inv_d = 1'b0; den_d = 1'b0; tag_d = '0;
         if (s1_valid_q) begin
            un_d = s1_info_q.nan;
            eq_d = ~un_d & (s1_info_q.zero | ((s1_info_q.sa == s1_info_q.sb) & s1_info_q.mag_eq));
            if (!un_d && !eq_d) begin
               if (s1_info_q.sa != s1_info_q.sb) lt_d = s1_info_q.sa;
               else if (s1_info_q.sa)           lt_d = ~s1_info_q.mag_lt & ~s1_info_q.mag_eq;
               else                             lt_d = s1_info_q.mag_lt;
               gt_d = ~lt_d;
            end
            if (un_d)      cc_d = CC_UN;
            else if (eq_d) cc_d = CC_EQ;
            else if (lt_d) cc_d = CC_LT;
            else           cc_d = CC_GT;
            inv_d = s1_info_q.inv;
            den_d = s1_info_q.den;
            tag_d = s1_tag_q;
         end
      end
   end

   // Sticky invalid: a delivered invalid beat wins over a same-cycle clear.
   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr)                        sticky_d = 1'b0;
      if (out_valid_q & out_ready & inv_q)   sticky_d = 1'b1;
   end

   // Pipeline and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_info_q   <= '0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         lt_q <= 1'b0; eq_q <= 1'b0; gt_q <= 1'b0; un_q <= 1'b0;
         cc_q <= '0; inv_q <= 1'b0; den_q <= 1'b0; tag_q <= '0;
         sticky_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_info_q   <= s1_info_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         lt_q <= lt_d; eq_q <= eq_d; gt_q <= gt_d; un_q <= un_d;
         cc_q <= cc_d; inv_q <= inv_d; den_q <= den_d; tag_q <= tag_d;
         sticky_q    <= sticky_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_lt         = lt_q;
   assign out_eq         = eq_q;
   assign out_gt         = gt_q;
   assign out_un         = un_q;
   assign out_cc         = cc_q;
   assign out_invalid    = inv_q;
   assign out_denormal   = den_q;
   assign out_tag        = tag_q;
   assign sticky_invalid = sticky_q;

endmodule

// File: tb/tb_fpu_cmp_pipe.sv
// Self-checking bench for fpu_cmp_pipe: directed points plus a randomized
// back-pressured stream checked against a real-arithmetic reference model.
module tb_fpu_cmp_pipe;

   typedef struct packed {
      logic       lt, eq, gt, un;
      logic [2:0] cc;
      logic       inv, den;
      logic [3:0] tag;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // double-precision, DAZ=1 instance
   logic        in_valid = 1'b0, in_ready, in_signaling = 1'b0;
   logic [63:0] in_a = '0, in_b = '0;
   logic [3:0]  in_tag = '0, out_tag;
   logic        out_valid, out_ready = 1'b1, out_lt, out_eq, out_gt, out_un;
   logic [2:0]  out_cc;
   logic        out_invalid, out_denormal, sticky_clr = 1'b0, sticky_invalid;
   res_t        obs;

   // single-precision, DAZ=0 instance
   logic        sp_in_valid = 1'b0, sp_in_ready;
   logic [31:0] sp_in_a = '0, sp_in_b = '0;
   logic [3:0]  sp_out_tag;
   logic        sp_out_valid, sp_lt, sp_eq, sp_gt, sp_un;
   logic [2:0]  sp_cc;
   logic        sp_inv, sp_den, sp_sticky;
   res_t        sp_obs;

   fpu_cmp_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signaling(in_signaling), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_lt(out_lt), .out_eq(out_eq),
      .out_gt(out_gt), .out_un(out_un), .out_cc(out_cc), .out_invalid(out_invalid),
      .out_denormal(out_denormal), .out_tag(out_tag), .sticky_clr(sticky_clr),
      .sticky_invalid(sticky_invalid));

   fpu_cmp_pipe #(.EXP_W(8), .FRAC_W(23), .DAZ(0), .TAG_W(4)) u_sp (
      .clk(clk), .rst_n(rst_n), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
      .in_a(sp_in_a), .in_b(sp_in_b), .in_signaling(in_signaling), .in_tag(in_tag),
      .out_valid(sp_out_valid), .out_ready(out_ready), .out_lt(sp_lt), .out_eq(sp_eq),
      .out_gt(sp_gt), .out_un(sp_un), .out_cc(sp_cc), .out_invalid(sp_inv),
      .out_denormal(sp_den), .out_tag(sp_out_tag), .sticky_clr(sticky_clr),
      .sticky_invalid(sp_sticky));

   assign obs    = {out_lt, out_eq, out_gt, out_un, out_cc, out_invalid, out_denormal, out_tag};
   assign sp_obs = {sp_lt, sp_eq, sp_gt, sp_un, sp_cc, sp_inv, sp_den, sp_out_tag};

   // Reference: NaN handling from field rules, ordering from real arithmetic (DAZ=1).
   function automatic res_t model64(input logic [63:0] a, input logic [63:0] b,
                                    input logic sig, input logic [3:0] tag);
      res_t r;
      logic na, nb, da, db;
      real  va, vb;
      na = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      nb = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      da = (a[62:52] == 11'h000) && (a[51:0] != 0);
      db = (b[62:52] == 11'h000) && (b[51:0] != 0);
      r     = '0;
      r.tag = tag;
      r.den = da | db;
      r.inv = (na && !a[51]) || (nb && !b[51]) || (sig && (na || nb));
      if (na || nb) begin
         r.un = 1'b1; r.cc = 3'b111;
      end else begin
         va = da ? 0.0 : $bitstoreal(a);
         vb = db ? 0.0 : $bitstoreal(b);
         if (va < vb)       begin r.lt = 1'b1; r.cc = 3'b001; end
         else if (va == vb) begin r.eq = 1'b1; r.cc = 3'b100; end
         else               begin r.gt = 1'b1; r.cc = 3'b000; end
      end
      return r;
   endfunction

   function automatic logic [63:0] rnd64();
      logic [63:0] r;
      logic [10:0] e;
      r = {$urandom(), $urandom()};
      e = 11'($urandom_range(1, 2046));
      case ($urandom_range(0, 6))
         0:       r = {r[63], 63'b0};
         1:       r = {r[63], 11'h000, r[51:1], 1'b1};
         2, 3:    r = {r[63], e, r[51:0]};
         4:       r = {r[63], 11'h7FF, 52'b0};
         5:       r = {r[63], 11'h7FF, 1'b1, r[50:0]};
         default: r = {r[63], 11'h7FF, 1'b0, r[50:1], 1'b1};
      endcase
      return r;
   endfunction

   // Issue one request on the double instance and wait (bounded) for its result.
   task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic sig,
                        input logic [3:0] tag, output bit got);
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_signaling = sig; in_tag = tag; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         if (out_valid) got = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic run_sp(input logic [31:0] a, input logic [31:0] b, output bit got);
      @(negedge clk);
      sp_in_valid = 1'b1; sp_in_a = a; sp_in_b = b; in_signaling = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      sp_in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         if (sp_out_valid) got = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || obs !== '0 || sticky_invalid !== 1'b0 || sp_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: valid=%b res=%h sticky=%b sp_valid=%b required 0", out_valid, obs, sticky_invalid, sp_out_valid);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_latency_lt();
      res_t exp_r;
      exp_r = model64(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 4'h3);
      @(negedge clk);
      in_valid = 1'b1; in_a = 64'h3FF0000000000000; in_b = 64'h4000000000000000;
      in_signaling = 1'b0; in_tag = 4'h3; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL latency_early: out_valid=%b after 1 cycle, required 0", out_valid);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || obs !== exp_r || out_lt !== 1'b1 || out_cc !== 3'b001) begin
         bad++; $display("FAIL lt_1_vs_2: valid=%b res=%h required valid=1 res=%h", out_valid, obs, exp_r);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || obs !== '0) begin
         bad++; $display("FAIL idle_zero: valid=%b res=%h required 0", out_valid, obs);
      end
   endtask

   task automatic test_zero_daz();
      bit got;
      run64(64'h8000000000000000, 64'h0000000000000000, 1'b0, 4'h1, got);
      total++;
      if (!got || out_eq !== 1'b1 || out_cc !== 3'b100 || out_denormal !== 1'b0) begin
         bad++; $display("FAIL neg_pos_zero: got=%0d eq=%b cc=%b den=%b required eq=1 cc=100 den=0", got, out_eq, out_cc, out_denormal);
      end
      run64(64'h0000000000000001, 64'h0000000000000000, 1'b0, 4'h2, got);
      total++;
      if (!got || out_eq !== 1'b1 || out_cc !== 3'b100 || out_denormal !== 1'b1 || out_tag !== 4'h2) begin
         bad++; $display("FAIL daz_denorm: got=%0d eq=%b cc=%b den=%b tag=%h required eq=1 cc=100 den=1 tag=2", got, out_eq, out_cc, out_denormal, out_tag);
      end
   endtask

   task automatic test_qnan();
      bit got;
      run64(64'h7FF8000000000000, 64'h3FF0000000000000, 1'b0, 4'h4, got);
      total++;
      if (!got || out_un !== 1'b1 || out_cc !== 3'b111 || out_invalid !== 1'b0 || {out_lt, out_eq, out_gt} !== 3'b000) begin
         bad++; $display("FAIL qnan_fucom: got=%0d res=%h required un=1 cc=111 inv=0", got, obs);
      end
      @(negedge clk);
      total++;
      if (sticky_invalid !== 1'b0) begin
         bad++; $display("FAIL sticky_quiet: got %b required 0", sticky_invalid);
      end
      run64(64'h7FF8000000000000, 64'h3FF0000000000000, 1'b1, 4'h5, got);
      total++;
      if (!got || out_un !== 1'b1 || out_invalid !== 1'b1) begin
         bad++; $display("FAIL qnan_fcom: got=%0d un=%b inv=%b required un=1 inv=1", got, out_un, out_invalid);
      end
      @(negedge clk);
      total++;
      if (sticky_invalid !== 1'b1) begin
         bad++; $display("FAIL sticky_set: got %b required 1", sticky_invalid);
      end
   endtask

   task automatic test_snan_sticky();
      bit got;
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      total++;
      if (sticky_invalid !== 1'b0) begin
         bad++; $display("FAIL sticky_clear: got %b required 0", sticky_invalid);
      end
      run64(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 4'h6, got);
      total++;
      if (!got || out_invalid !== 1'b1 || out_un !== 1'b1) begin
         bad++; $display("FAIL snan_fucom: got=%0d inv=%b un=%b required inv=1 un=1", got, out_invalid, out_un);
      end
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      total++;
      if (sticky_invalid !== 1'b1) begin
         bad++; $display("FAIL sticky_set_wins: got %b required 1", sticky_invalid);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 64;
      res_t       exp_q[$];
      res_t       held, e;
      bit         stalled = 1'b0, accepted = 1'b0, hold_bad = 1'b0, zero_bad = 1'b0;
      int         sent = 0, rcvd = 0, cyc = 0;
      logic [63:0] a, b;
      while (rcvd < N && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (stalled && (out_valid !== 1'b1 || obs !== held)) begin
            if (!hold_bad) $display("FAIL stall_hold: res=%h required %h", obs, held);
            hold_bad = 1'b1;
         end
         if (!out_valid && obs !== '0) begin
            if (!zero_bad) $display("FAIL stream_idle_zero: res=%h required 0", obs);
            zero_bad = 1'b1;
         end
         if (accepted) in_valid = 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
            a = rnd64();
            case ($urandom_range(0, 7))
               0, 1:    b = a;
               2:       b = a ^ 64'h8000000000000000;
               3:       b = a + 64'd1;
               default: b = rnd64();
            endcase
            in_a = a; in_b = b; in_signaling = 1'($urandom_range(0, 1));
            in_tag = 4'(sent); in_valid = 1'b1;
         end
         #1;
         accepted = in_valid && in_ready;
         if (accepted) begin
            exp_q.push_back(model64(in_a, in_b, in_signaling, in_tag));
            sent++;
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL stream_extra: unexpected result %h", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  bad++; $display("FAIL stream_result %0d: got %h required %h", rcvd, obs, e);
               end
            end
            rcvd++;
         end
         stalled = out_valid && !out_ready;
         held    = obs;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (rcvd != N || hold_bad || zero_bad) begin
         bad++; $display("FAIL stream_summary: delivered=%0d required %0d hold_err=%0d zero_err=%0d", rcvd, N, hold_bad, zero_bad);
      end
   endtask

   task automatic test_single_and_reset();
      bit got;
      bit seen = 1'b0;
      run_sp(32'hC0000000, 32'hBF800000, got);
      total++;
      if (!got || sp_lt !== 1'b1 || sp_cc !== 3'b001 || {sp_eq, sp_gt, sp_un} !== 3'b000) begin
         bad++; $display("FAIL sp_neg2_lt_neg1: got=%0d res=%h required lt=1 cc=001", got, sp_obs);
      end
      run_sp(32'h00000001, 32'h00000000, got);
      total++;
      if (!got || sp_gt !== 1'b1 || sp_cc !== 3'b000 || sp_den !== 1'b1) begin
         bad++; $display("FAIL sp_exact_denorm_gt: got=%0d res=%h required gt=1 cc=000 den=1", got, sp_obs);
      end
      run_sp(32'h80000001, 32'h80000000, got);
      total++;
      if (!got || sp_lt !== 1'b1 || sp_den !== 1'b1) begin
         bad++; $display("FAIL sp_neg_denorm_lt: got=%0d res=%h required lt=1 den=1", got, sp_obs);
      end
      // two requests in flight, output held, then reset
      @(negedge clk);
      out_ready = 1'b0;
      sp_in_valid = 1'b1; sp_in_a = 32'h3F800000; sp_in_b = 32'h40000000;
      @(negedge clk);
      sp_in_a = 32'h40000000; sp_in_b = 32'h3F800000;
      @(negedge clk);
      sp_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (sp_out_valid !== 1'b0 || sp_obs !== '0) begin
         bad++; $display("FAIL async_reset: valid=%b res=%h required 0", sp_out_valid, sp_obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      total++;
      if (sp_in_ready !== 1'b1) begin
         bad++; $display("FAIL sp_ready_after_reset: got %b required 1", sp_in_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (sp_out_valid !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++; $display("FAIL discard_in_flight: out_valid seen after reset, required none");
      end
   endtask

   initial begin
      test_reset();
      test_latency_lt();
      test_zero_daz();
      test_qnan();
      test_snan_sticky();
      test_back_to_back();
      test_single_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
